// File: rtl/wb_conbus_rr.sv
// Wishbone shared bus, NM masters to NS slaves: registered round-robin grant held for the whole cyc,
// top-address-bit decode, ack/err/data routed from the selected slave only, unmapped and watchdog errors.
module wb_conbus_rr #(
  parameter int                  NM       = 2,
  parameter int                  NS       = 7,
  parameter int                  AW       = 32,
  parameter int                  DW       = 32,
  parameter int                  DEC_W    = 3,
  parameter logic [NS*DEC_W-1:0] SLV_ADDR = 21'h1AC688,
  parameter int                  TIMEOUT  = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NM*DW-1:0]     m_dat_i,
  output logic [DW-1:0]        m_dat_o,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*3-1:0]      m_cti_i,
  input  logic [NM*(DW/8)-1:0] m_sel_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [2:0]           s_cti_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic                 s_we_o,
  output logic [NS-1:0]        s_cyc_o,
  output logic [NS-1:0]        s_stb_o,
  input  logic [NS*DW-1:0]     s_dat_i,
  input  logic [NS-1:0]        s_ack_i,
  input  logic [NS-1:0]        s_err_i,
  output logic [NM-1:0]        gnt_o
);

  localparam int SW = DW / 8;
  localparam int LW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {IDLE, OWNED} state_e;

  state_e        state_q, state_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic [LW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat;
  logic [2:0]    own_cti;
  logic [SW-1:0] own_sel;
  logic          own_we, own_cyc, own_stb;
  logic [NS-1:0] slv_sel;
  logic          mapped, ack_hit, err_hit, gnt_chg, to_fire, unm_fire;

  // Search starts just after the last owner and wraps round to it.
  function automatic logic [NM-1:0] rr_pick(input logic [NM-1:0] req, input logic [LW-1:0] last);
    logic [NM-1:0] pick;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (!found && req[i] && i > int'(last)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (!found && req[i] && i <= int'(last)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(NM - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = rr_pick(m_cyc_i, last_q);
          state_d = OWNED;
        end
      end
      OWNED: begin
        // Owner released: hand over on this same edge if anyone else is waiting.
        if (!own_cyc) begin
          gnt_d   = rr_pick(m_cyc_i & ~gnt_q, last_q);
          state_d = (|(m_cyc_i & ~gnt_q)) ? OWNED : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    last_d = last_q;
    for (int k = 0; k < NM; k++) begin
      if (gnt_d[k]) last_d = LW'(k);
    end
  end

  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_cti = '0;
    own_sel = '0;
    own_we  = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (gnt_q[k]) begin
        own_adr = own_adr | m_adr_i[k*AW +: AW];
        own_dat = own_dat | m_dat_i[k*DW +: DW];
        own_cti = own_cti | m_cti_i[k*3 +: 3];
        own_sel = own_sel | m_sel_i[k*SW +: SW];
        own_we  = own_we  | m_we_i[k];
      end
    end
  end

  assign own_cyc = |(gnt_q & m_cyc_i);
  assign own_stb = |(gnt_q & m_stb_i);

  always_comb begin
    slv_sel = '0;
    mapped  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!mapped && (|gnt_q) && own_adr[AW-1 -: DEC_W] == SLV_ADDR[i*DEC_W +: DEC_W]) begin
        slv_sel[i] = 1'b1;
        mapped     = 1'b1;
      end
    end
  end

  assign ack_hit = own_stb & (|(s_ack_i & slv_sel));
  assign err_hit = own_stb & (|(s_err_i & slv_sel));
  assign gnt_chg = (gnt_d != gnt_q);
  assign unm_fire = own_stb & ~mapped & ~err_q;

  // Internal error goes to the current owner only; a grant change drops it.
  always_comb begin
    cnt_d   = '0;
    to_fire = 1'b0;
    if (TIMEOUT > 0 && own_stb && mapped && !ack_hit && !err_hit && !err_q && !gnt_chg) begin
      if (cnt_q == TO_LAST) to_fire = 1'b1;
      else                  cnt_d   = cnt_q + CW'(1);
    end
    err_d = (unm_fire | to_fire) & ~gnt_chg;
  end

  always_comb begin
    m_dat_o = '0;
    for (int i = 0; i < NS; i++) begin
      if (slv_sel[i]) m_dat_o = m_dat_o | s_dat_i[i*DW +: DW];
    end
  end

  assign m_ack_o = gnt_q & {NM{ack_hit}};
  assign m_err_o = gnt_q & {NM{err_hit | err_q}};
  assign s_dat_o = own_dat;
  assign s_adr_o = own_adr;
  assign s_cti_o = own_cti;
  assign s_sel_o = own_sel;
  assign s_we_o  = own_we;
  assign s_cyc_o = {NS{own_cyc}} & slv_sel;
  assign s_stb_o = {NS{own_stb}} & slv_sel;
  assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed bench for wb_conbus_rr: main instance with TIMEOUT=16, second instance with NS=6 for unmapped decode.
module tb_wb_conbus_rr;
  localparam int NM = 2;
  localparam int NS = 7;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [NM*DW-1:0]  m_dat_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*3-1:0]   m_cti_i;
  logic [NM*4-1:0]   m_sel_i;
  logic [NM-1:0]     m_we_i, m_cyc_i, m_stb_i, m_ack_o, m_err_o, gnt_o;
  logic [DW-1:0]     s_dat_o;
  logic [AW-1:0]     s_adr_o;
  logic [2:0]        s_cti_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [NS*DW-1:0]  s_dat_i;

  logic [DW-1:0]     b_m_dat_o, b_s_dat_o;
  logic [AW-1:0]     b_s_adr_o;
  logic [2:0]        b_s_cti_o;
  logic [3:0]        b_s_sel_o;
  logic              b_s_we_o;
  logic [NM-1:0]     b_m_ack_o, b_m_err_o, b_gnt_o;
  logic [5:0]        b_s_cyc_o, b_s_stb_o, b_s_ack_i, b_s_err_i;
  logic [6*DW-1:0]   b_s_dat_i;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  wb_conbus_rr #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .TIMEOUT(16)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_adr_i(m_adr_i), .m_cti_i(m_cti_i),
    .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_cti_o(s_cti_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  wb_conbus_rr #(.NM(NM), .NS(6), .AW(AW), .DW(DW), .SLV_ADDR(18'h2C688)) u_dut6 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m_dat_i(m_dat_i), .m_dat_o(b_m_dat_o), .m_adr_i(m_adr_i), .m_cti_i(m_cti_i),
    .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_ack_o(b_m_ack_o), .m_err_o(b_m_err_o),
    .s_dat_o(b_s_dat_o), .s_adr_o(b_s_adr_o), .s_cti_o(b_s_cti_o), .s_sel_o(b_s_sel_o),
    .s_we_o(b_s_we_o), .s_cyc_o(b_s_cyc_o), .s_stb_o(b_s_stb_o),
    .s_dat_i(b_s_dat_i), .s_ack_i(b_s_ack_i), .s_err_i(b_s_err_i), .gnt_o(b_gnt_o)
  );

  task automatic next_cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    m_dat_i = '0; m_adr_i = '0; m_cti_i = '0; m_sel_i = '0;
    m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    s_ack_i = '0; s_err_i = '0; s_dat_i = '0;
    s_dat_i[0*DW +: DW] = 32'h1111_1111;
    s_dat_i[1*DW +: DW] = 32'hDEAD_BEEF;
    b_s_ack_i = '0; b_s_err_i = '0; b_s_dat_i = '0;
    repeat (2) @(posedge sys_clk);
    #2;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt_o); end
    checks++; if (m_dat_o !== 32'h0) begin errors++; $display("FAIL reset_mdat got %h want 0", m_dat_o); end
    checks++; if (s_cyc_o !== 7'h0 || s_stb_o !== 7'h0) begin errors++; $display("FAIL reset_scyc got %b/%b want 0/0", s_cyc_o, s_stb_o); end
    checks++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin errors++; $display("FAIL reset_resp got %b/%b want 00/00", m_ack_o, m_err_o); end
    next_cyc();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    next_cyc();
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    m_adr_i[0 +: AW] = 32'h2000_0000; m_sel_i[3:0] = 4'hF;
    #2;
    checks++; if (gnt_o !== 2'b00 || s_stb_o !== 7'h0) begin errors++; $display("FAIL read_latency got gnt %b stb %b want 00/0", gnt_o, s_stb_o); end
    next_cyc(); #2;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL read_gnt got %b want 01", gnt_o); end
    checks++; if (s_stb_o !== 7'b0000010 || s_cyc_o !== 7'b0000010) begin errors++; $display("FAIL read_decode got %b/%b want 0000010", s_stb_o, s_cyc_o); end
    checks++; if (s_adr_o !== 32'h2000_0000) begin errors++; $display("FAIL read_adr got %h want 20000000", s_adr_o); end
    next_cyc(); #2;
    checks++; if (m_ack_o !== 2'b00) begin errors++; $display("FAIL read_wait_ack got %b want 00", m_ack_o); end
    next_cyc();
    s_ack_i = 7'b0000010;
    #2;
    checks++; if (m_ack_o !== 2'b01) begin errors++; $display("FAIL read_ack got %b want 01", m_ack_o); end
    checks++; if (m_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data got %h want deadbeef", m_dat_o); end
    next_cyc();
    s_ack_i = '0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
    #2;
    checks++; if (m_ack_o !== 2'b00 || gnt_o !== 2'b01) begin errors++; $display("FAIL read_end got ack %b gnt %b want 00/01", m_ack_o, gnt_o); end
    next_cyc(); #2;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL read_idle got %b want 00", gnt_o); end
  endtask

  task automatic test_alternate();
    logic [1:0] cyc_v [9];
    logic [1:0] gnt_v [9];
    logic [1:0] ack_v [9];
    logic [6:0] stb_v [9];
    cyc_v = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00};
    gnt_v = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    ack_v = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    stb_v = '{7'h00, 7'h04, 7'h00, 7'h08, 7'h00, 7'h04, 7'h00, 7'h08, 7'h00};
    sys_rst_n = 1'b0;
    next_cyc();
    sys_rst_n = 1'b1;
    m_adr_i[0 +: AW] = 32'h4000_0000;
    m_adr_i[AW +: AW] = 32'h6000_0000;
    s_ack_i = 7'h7F;
    for (int t = 0; t < 9; t++) begin
      next_cyc();
      m_cyc_i = cyc_v[t]; m_stb_i = cyc_v[t];
      #2;
      checks++; if (gnt_o !== gnt_v[t]) begin errors++; $display("FAIL alt_gnt[%0d] got %b want %b", t, gnt_o, gnt_v[t]); end
      checks++; if (m_ack_o !== ack_v[t]) begin errors++; $display("FAIL alt_ack[%0d] got %b want %b", t, m_ack_o, ack_v[t]); end
      checks++; if (s_stb_o !== stb_v[t]) begin errors++; $display("FAIL alt_stb[%0d] got %b want %b", t, s_stb_o, stb_v[t]); end
    end
    s_ack_i = '0;
  endtask

  task automatic test_burst();
    logic [1:0] cyc_v [9];
    logic       ak3_v [9];
    logic [1:0] gnt_v [9];
    logic [1:0] ack_v [9];
    int m0_acks, m1_acks;
    cyc_v = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
    ak3_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    gnt_v = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    ack_v = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
    m0_acks = 0; m1_acks = 0;
    for (int t = 0; t < 9; t++) begin
      next_cyc();
      m_cyc_i = cyc_v[t]; m_stb_i = cyc_v[t];
      s_ack_i = '0;
      s_ack_i[2] = (t < 8);
      s_ack_i[3] = ak3_v[t];
      #2;
      if (t < 7) begin
        m0_acks += int'(m_ack_o[0]);
        m1_acks += int'(m_ack_o[1]);
      end
      checks++; if (gnt_o !== gnt_v[t]) begin errors++; $display("FAIL burst_gnt[%0d] got %b want %b", t, gnt_o, gnt_v[t]); end
      checks++; if (m_ack_o !== ack_v[t]) begin errors++; $display("FAIL burst_ack[%0d] got %b want %b", t, m_ack_o, ack_v[t]); end
    end
    checks++; if (m0_acks !== 0) begin errors++; $display("FAIL burst_m0_acks got %0d want 0", m0_acks); end
    checks++; if (m1_acks !== 4) begin errors++; $display("FAIL burst_m1_acks got %0d want 4", m1_acks); end
    s_ack_i = '0;
  endtask

  task automatic test_unmapped();
    logic [1:0] err_v [8];
    err_v = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    m_adr_i[0 +: AW] = 32'hE000_0000;
    for (int t = 0; t < 8; t++) begin
      next_cyc();
      m_cyc_i = (t < 6) ? 2'b01 : 2'b00;
      m_stb_i = m_cyc_i;
      #2;
      checks++; if (m_err_o !== err_v[t]) begin errors++; $display("FAIL unm_err[%0d] got %b want %b", t, m_err_o, err_v[t]); end
      checks++; if (b_m_err_o !== err_v[t]) begin errors++; $display("FAIL unm6_err[%0d] got %b want %b", t, b_m_err_o, err_v[t]); end
      checks++; if (s_cyc_o !== 7'h0 || s_stb_o !== 7'h0 || b_s_cyc_o !== 6'h0) begin errors++; $display("FAIL unm_scyc[%0d] got %b/%b/%b want 0", t, s_cyc_o, s_stb_o, b_s_cyc_o); end
      checks++; if (m_ack_o !== 2'b00) begin errors++; $display("FAIL unm_ack[%0d] got %b want 00", t, m_ack_o); end
    end
  endtask

  task automatic test_timeout();
    logic [1:0] exp_err, exp_gnt, exp_ack;
    m_adr_i[0 +: AW] = 32'h6000_0000;
    // Slave 3 silent: single error 16 cycles after the slave first sees stb (w1).
    for (int w = 0; w < 20; w++) begin
      next_cyc();
      m_cyc_i = (w < 19) ? 2'b01 : 2'b00;
      m_stb_i = m_cyc_i;
      s_ack_i = (w == 8) ? 7'b0100000 : 7'b0;
      #2;
      exp_err = (w == 17) ? 2'b01 : 2'b00;
      exp_gnt = (w == 0) ? 2'b00 : 2'b01;
      checks++; if (m_err_o !== exp_err) begin errors++; $display("FAIL to_err[%0d] got %b want %b", w, m_err_o, exp_err); end
      checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL to_gnt[%0d] got %b want %b", w, gnt_o, exp_gnt); end
      checks++; if (m_ack_o !== 2'b00) begin errors++; $display("FAIL to_ack[%0d] got %b want 00", w, m_ack_o); end
      if (w == 1) begin
        checks++; if (s_stb_o !== 7'b0001000) begin errors++; $display("FAIL to_stb got %b want 0001000", s_stb_o); end
      end
    end
    // Ack lands on the very cycle the count would expire: ack wins.
    for (int x = 0; x < 19; x++) begin
      next_cyc();
      m_cyc_i = (x <= 16) ? 2'b01 : 2'b00;
      m_stb_i = m_cyc_i;
      s_ack_i = (x == 16) ? 7'b0001000 : 7'b0;
      #2;
      exp_ack = (x == 16) ? 2'b01 : 2'b00;
      checks++; if (m_ack_o !== exp_ack) begin errors++; $display("FAIL tack_ack[%0d] got %b want %b", x, m_ack_o, exp_ack); end
      checks++; if (m_err_o !== 2'b00) begin errors++; $display("FAIL tack_err[%0d] got %b want 00", x, m_err_o); end
    end
    s_ack_i = '0;
  endtask

  task automatic test_reset_midburst();
    next_cyc();
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
    m_adr_i[AW +: AW] = 32'h2000_0004; m_sel_i[7:4] = 4'hF;
    m_dat_i[DW +: DW] = 32'hCAFE_F00D; m_cti_i[5:3] = 3'b010;
    #2;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rst_pre_gnt got %b want 00", gnt_o); end
    next_cyc();
    s_ack_i = 7'b0000010;
    #2;
    checks++; if (gnt_o !== 2'b10 || m_ack_o !== 2'b10) begin errors++; $display("FAIL rst_beat got gnt %b ack %b want 10/10", gnt_o, m_ack_o); end
    checks++; if (s_we_o !== 1'b1 || s_dat_o !== 32'hCAFE_F00D || s_cti_o !== 3'b010 || s_sel_o !== 4'hF || s_adr_o !== 32'h2000_0004)
      begin errors++; $display("FAIL rst_bcast got we %b dat %h cti %b sel %h adr %h want 1 cafef00d 010 f 20000004", s_we_o, s_dat_o, s_cti_o, s_sel_o, s_adr_o); end
    checks++; if (m_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_mdat got %h want deadbeef", m_dat_o); end
    next_cyc();
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++; if (gnt_o !== 2'b00 || m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin errors++; $display("FAIL rst_async_ctl got %b/%b/%b want 00", gnt_o, m_ack_o, m_err_o); end
    checks++; if (s_cyc_o !== 7'h0 || s_stb_o !== 7'h0 || s_we_o !== 1'b0) begin errors++; $display("FAIL rst_async_scyc got %b/%b/%b want 0", s_cyc_o, s_stb_o, s_we_o); end
    checks++; if (s_adr_o !== 32'h0 || s_dat_o !== 32'h0 || m_dat_o !== 32'h0 || s_sel_o !== 4'h0 || s_cti_o !== 3'h0)
      begin errors++; $display("FAIL rst_async_bus got adr %h dat %h mdat %h sel %h cti %b want 0", s_adr_o, s_dat_o, m_dat_o, s_sel_o, s_cti_o); end
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    m_adr_i[0 +: AW] = 32'h4000_0000;
    next_cyc();
    next_cyc();
    sys_rst_n = 1'b1;
    #2;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL rst_release_gnt got %b want 00", gnt_o); end
    next_cyc(); #2;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rst_first_prio got %b want 01", gnt_o); end
    next_cyc();
    m_cyc_i = 2'b00; m_stb_i = 2'b00; s_ack_i = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_burst();
    test_unmapped();
    test_timeout();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit got still running want finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_conbus_rr.md
Name: wb_conbus_rr

Overview:
- Parametrised Wishbone shared-bus interconnect: NM masters to NS slaves.
- Registered round-robin arbiter with bus ownership held for the full cycle.
- Per-slave address decode from top address bits; ack and data are routed only from the selected slave.
- Built-in error responder for unmapped addresses and a watchdog timeout; sits between CPU/DMA masters and the SoC peripherals.

Parameters:
- NM, 2, number of masters (1..8)
- NS, 7, number of slaves (1..16)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- DEC_W, 3, number of top address bits decoded (adr[AW-1 -: DEC_W])
- SLV_ADDR, 21'h1AC688, packed decode values; slave i uses bits [i*DEC_W +: DEC_W] (default slave i = i)
- TIMEOUT, 255, cycles of unacknowledged stb before error; 0 disables

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- m_dat_i  in  NM*DW  master write data, master k at [k*DW +: DW]
- m_dat_o  out  DW  read data, broadcast to all masters
- m_adr_i  in  NM*AW  master addresses
- m_cti_i  in  NM*3  master cycle type
- m_sel_i  in  NM*DW/8  master byte selects
- m_we_i  in  NM  write enables
- m_cyc_i  in  NM  cycle requests
- m_stb_i  in  NM  strobes
- m_ack_o  out  NM  per-master ack
- m_err_o  out  NM  per-master error
- s_dat_o  out  DW  write data, broadcast to all slaves
- s_adr_o  out  AW  address, broadcast
- s_cti_o  out  3  cycle type, broadcast
- s_sel_o  out  DW/8  byte selects, broadcast
- s_we_o  out  1  write enable, broadcast
- s_cyc_o  out  NS  per-slave cyc, qualified by decode
- s_stb_o  out  NS  per-slave stb, qualified by decode
- s_dat_i  in  NS*DW  slave read data
- s_ack_i  in  NS  slave acks
- s_err_i  in  NS  slave errors
- gnt_o  out  NM  current one-hot grant (debug/perf)

Behaviour:
- Reset is asynchronous on sys_rst_n low and applies immediately, including mid-transfer:
  - gnt=0; rr pointer set so master 0 has first priority; timeout counter=0; internal err=0.
  - All outputs 0: every broadcast signal is forced to 0 when gnt=0.
- Arbiter states:
  - IDLE (gnt=0): if any m_cyc_i, register a one-hot grant to the first requester searching from (last owner+1) mod NM → OWNED.
  - OWNED: hold the grant while the owner's cyc=1.
  - On an owner cyc falling edge with other requesters pending, switch directly to the next rr requester at that edge, with no idle cycle; otherwise → IDLE.
- Grant latency: cyc asserted in cycle n → gnt_o and slave cyc/stb in cycle n+1. Master inputs are otherwise combinationally muxed by gnt.
- Decode:
  - Combinational match of the owner's adr top DEC_W bits against SLV_ADDR; lowest index wins on duplicates.
  - s_cyc_o[i] = owner cyc & sel[i]; s_stb_o[i] = owner stb & sel[i].
- Response routing:
  - m_ack_o[k] = gnt[k] & owner stb & s_ack_i[sel]; m_err_o likewise from s_err_i[sel], OR'd with internal errors.
  - Ack/err from unselected slaves, or while stb=0, are ignored.
  - m_dat_o = s_dat_i of the selected slave, 0 if none.
- Unmapped address: registered error pulse one cycle after stb seen with no match (next edge). It is suppressed for one cycle after firing, so a held stb gets err every second cycle. No slave sees cyc/stb.
- Watchdog (TIMEOUT>0):
  - Counter clears on ack, err, stb=0, or grant change; otherwise increments while stb is high to a mapped slave.
  - When count reaches TIMEOUT-1, the next edge registers a one-cycle m_err_o to the owner and clears the counter.
  - Ack and timeout on the same cycle: ack wins, no err.
- Back-to-back strobes within one cyc (burst) keep the grant; the counter restarts per beat.
- A non-owner's ack/err is always 0.

Test Plan:
- Reset release, m0 cyc/stb adr=0x2000_0000 read, slave 1 acks 2 cycles later with 0xDEADBEEF → gnt_o=01 one cycle after cyc, s_stb_o=0000010, m_ack_o[0] pulse, m_dat_o=0xDEADBEEF.
- m0 and m1 request continuously, each a single-beat cycle → grants alternate 01,10,01,10 with no idle cycle between owners.
- m1 holds cyc over a 4-beat burst while m0 requests → m0 granted only on the edge after m1 cyc falls; m0 ack count=0 during the burst.
- NS=6, adr top bits=7 (unmapped), stb held → m_err_o pulses every second cycle, s_cyc_o=0 throughout.
- Slave 3 never acks, TIMEOUT=16 → m_err_o single pulse 16 cycles after stb, counter cleared; a spurious s_ack_i[5] in the meantime is ignored.
- Assert sys_rst_n low mid-burst → all outputs 0 without a clock edge; after release, master 0 wins a simultaneous request.
